// File: rtl/pe_int_mw.sv
// Weight-stationary signed MAC processing element with a selectable weight bank.
// Three-stage pipeline: operand capture, multiply, add (pass-through or local accumulate).
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   load_en/_addr    write weight_in into bank[load_addr]
//   in_valid         sample on ifmap_in/psum_in/w_sel/acc_mode/in_last
//   ifmap_in         activation, forwarded as ifmap_out one cycle later
//   psum_in          incoming partial sum (mode 0 only)
//   w_sel            bank slot used by this sample
//   acc_mode         0 = product + psum_in, 1 = accumulate locally
//   in_last          closes an accumulate group and emits its sum
//   ifmap_out/ifmap_valid_out  registered ifmap_in/in_valid
//   psum_out/out_valid         result, three cycles after the sample
module pe_int_mw #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int NUM_W  = 4,
    parameter int SAT    = 1,
    localparam int AW    = $clog2(NUM_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [DATA_W-1:0] weight_in,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] ifmap_in,
    input  logic [ACC_W-1:0]  psum_in,
    input  logic [AW-1:0]     w_sel,
    input  logic              acc_mode,
    input  logic              in_last,
    output logic [DATA_W-1:0] ifmap_out,
    output logic              ifmap_valid_out,
    output logic [ACC_W-1:0]  psum_out,
    output logic              out_valid
);

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [2*DATA_W-1:0] prod_t;

    localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Overflow only when both operands share a sign the result lacks.
    function automatic acc_t add_acc(input acc_t a, input acc_t b);
        acc_t s;
        s = a + b;
        if (SAT != 0 && a[ACC_W-1] == b[ACC_W-1] && s[ACC_W-1] != a[ACC_W-1])
            s = a[ACC_W-1] ? ACC_MIN : ACC_MAX;
        return s;
    endfunction

    logic [DATA_W-1:0] bank_q [NUM_W];

    // Stage 1: the ifmap register doubles as the forwarded ifmap.
    logic [DATA_W-1:0] s1_ifmap_q;
    logic [DATA_W-1:0] s1_w_q;
    acc_t              s1_psum_q;
    logic              s1_vld_q;
    logic              s1_mode_q;
    logic              s1_last_q;

    // Stage 2
    acc_t              s2_prod_q;
    acc_t              s2_psum_q;
    logic              s2_vld_q;
    logic              s2_mode_q;
    logic              s2_last_q;

    // Stage 3
    acc_t              acc_q, acc_d;
    acc_t              psum_q, psum_d;
    logic              ov_q, ov_d;

    prod_t             prod_d;
    acc_t              sum_d;

    assign prod_d = $signed(s1_ifmap_q) * $signed(s1_w_q);

    always_comb begin
        sum_d  = add_acc(s2_mode_q ? acc_q : s2_psum_q, s2_prod_q);
        acc_d  = acc_q;
        psum_d = psum_q;
        ov_d   = 1'b0;
        if (s2_vld_q) begin
            if (!s2_mode_q) begin
                psum_d = sum_d;
                ov_d   = 1'b1;
            end else if (s2_last_q) begin
                psum_d = sum_d;
                ov_d   = 1'b1;
                acc_d  = '0;
            end else begin
                acc_d  = sum_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_W; i++)
                bank_q[i] <= '0;
            s1_ifmap_q <= '0;
            s1_w_q     <= '0;
            s1_psum_q  <= '0;
            s1_vld_q   <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_prod_q  <= '0;
            s2_psum_q  <= '0;
            s2_vld_q   <= 1'b0;
            s2_mode_q  <= 1'b0;
            s2_last_q  <= 1'b0;
            acc_q      <= '0;
            psum_q     <= '0;
            ov_q       <= 1'b0;
        end else begin
            // Nonblocking read sees the pre-write bank contents.
            if (load_en)
                bank_q[load_addr] <= weight_in;
            s1_ifmap_q <= ifmap_in;
            s1_w_q     <= bank_q[w_sel];
            s1_psum_q  <= psum_in;
            s1_vld_q   <= in_valid;
            s1_mode_q  <= acc_mode;
            s1_last_q  <= in_last;
            s2_prod_q  <= acc_t'(prod_d);
            s2_psum_q  <= s1_psum_q;
            s2_vld_q   <= s1_vld_q;
            s2_mode_q  <= s1_mode_q;
            s2_last_q  <= s1_last_q;
            acc_q      <= acc_d;
            psum_q     <= psum_d;
            ov_q       <= ov_d;
        end
    end

    assign ifmap_out       = s1_ifmap_q;
    assign ifmap_valid_out = s1_vld_q;
    assign psum_out        = psum_q;
    assign out_valid       = ov_q;

endmodule

// File: tb/tb_pe_int_mw.sv
// Bench for pe_int_mw: directed plan plus random traffic against a queue model.
// A saturating and a wrapping instance share all inputs.
module tb_pe_int_mw;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_en = 1'b0;
    logic [1:0]  load_addr = '0;
    logic [7:0]  weight_in = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  ifmap_in = '0;
    logic [23:0] psum_in = '0;
    logic [1:0]  w_sel = '0;
    logic        acc_mode = 1'b0;
    logic        in_last = 1'b0;

    logic [7:0]  ifmap_out, ifmap_out_w;
    logic        ifmap_valid_out, ifmap_valid_out_w;
    logic [23:0] psum_out, psum_out_w;
    logic        out_valid, out_valid_w;

    always #5 clk = ~clk;

    pe_int_mw #(.DATA_W(8), .ACC_W(24), .NUM_W(4), .SAT(1)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .weight_in(weight_in), .in_valid(in_valid), .ifmap_in(ifmap_in),
        .psum_in(psum_in), .w_sel(w_sel), .acc_mode(acc_mode), .in_last(in_last),
        .ifmap_out(ifmap_out), .ifmap_valid_out(ifmap_valid_out),
        .psum_out(psum_out), .out_valid(out_valid)
    );

    pe_int_mw #(.DATA_W(8), .ACC_W(24), .NUM_W(4), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .weight_in(weight_in), .in_valid(in_valid), .ifmap_in(ifmap_in),
        .psum_in(psum_in), .w_sel(w_sel), .acc_mode(acc_mode), .in_last(in_last),
        .ifmap_out(ifmap_out_w), .ifmap_valid_out(ifmap_valid_out_w),
        .psum_out(psum_out_w), .out_valid(out_valid_w)
    );

    typedef struct {
        bit     v;
        longint ps;
        longint pw;
    } res_t;

    int     n_assert = 0;
    int     n_fail = 0;
    longint bank_m [4];
    longint acc_s, acc_w;
    res_t   pend [$];
    bit     eo_v;
    longint eo_ps, eo_pw, e_if;
    bit     e_ifv;

    localparam longint AMAX = 64'sd8388607;
    localparam longint AMIN = -64'sd8388608;

    function automatic longint addf(input longint a, input longint b, input bit sat);
        longint s;
        s = a + b;
        if (sat) begin
            if (s > AMAX) s = AMAX;
            if (s < AMIN) s = AMIN;
        end else begin
            s = s & 64'hFFFFFF;
            if (s > AMAX) s = s - 64'sd16777216;
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) bank_m[i] = 0;
        pend.delete();
        acc_s = 0; acc_w = 0;
        eo_v = 0; eo_ps = 0; eo_pw = 0;
        e_if = 0; e_ifv = 0;
    endtask

    task automatic step(input bit r, input bit le, input int la, input int wi,
                        input bit v, input int x, input int p, input int ws,
                        input bit m, input bit l);
        res_t   res;
        longint prod, ss, sw;
        rst = r; load_en = le; load_addr = la[1:0]; weight_in = wi[7:0];
        in_valid = v; ifmap_in = x[7:0]; psum_in = p[23:0];
        w_sel = ws[1:0]; acc_mode = m; in_last = l;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            e_if = x; e_ifv = v;
            res.v = 0; res.ps = 0; res.pw = 0;
            if (v) begin
                prod = bank_m[ws] * longint'(x);
                if (!m) begin
                    res.v = 1;
                    res.ps = addf(prod, p, 1);
                    res.pw = addf(prod, p, 0);
                end else begin
                    ss = addf(acc_s, prod, 1);
                    sw = addf(acc_w, prod, 0);
                    if (l) begin
                        res.v = 1; res.ps = ss; res.pw = sw;
                        acc_s = 0; acc_w = 0;
                    end else begin
                        acc_s = ss; acc_w = sw;
                    end
                end
            end
            if (le) bank_m[la] = wi;
            pend.push_back(res);
            if (pend.size() > 2) begin
                res = pend.pop_front();
                eo_v = res.v;
                if (res.v) begin
                    eo_ps = res.ps;
                    eo_pw = res.pw;
                end
            end
        end
        #1;
        chk("ifmap_out", $signed(ifmap_out), e_if);
        chk("ifmap_valid_out", ifmap_valid_out, e_ifv);
        chk("out_valid", out_valid, eo_v);
        chk("psum_out", $signed(psum_out), eo_ps);
        chk("out_valid_w", out_valid_w, eo_v);
        chk("psum_out_w", $signed(psum_out_w), eo_pw);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load(input int a, input int w);
        step(0, 1, a, w, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic smp(input int x, input int p, input int ws, input bit m, input bit l);
        step(0, 0, 0, 0, 1, x, p, ws, m, l);
    endtask

    int x, p, w;

    initial begin
        model_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 9, 9, 0, 0, 0);
        chk("rst_psum", $signed(psum_out), 0);
        chk("rst_ovld", out_valid, 0);

        load(0, 3);
        load(1, -2);
        smp(5, 10, 0, 0, 0);
        chk("t1_ifmap", $signed(ifmap_out), 5);
        chk("t1_ifvld", ifmap_valid_out, 1);
        idle();
        chk("t1_early", out_valid, 0);
        idle();
        chk("t1_psum", $signed(psum_out), 25);
        chk("t1_ovld", out_valid, 1);
        idle();
        chk("t1_after", out_valid, 0);

        smp(-4, 0, 1, 0, 0);
        idle(); idle();
        chk("t2_neg", $signed(psum_out), 8);
        load(2, -128);
        smp(-128, 0, 2, 0, 0);
        idle(); idle();
        chk("t2_min", $signed(psum_out), 16384);

        load(0, 2);
        smp(1, 0, 0, 0, 0);
        smp(2, 0, 0, 0, 0);
        smp(3, 1, 0, 0, 0);
        chk("t3_o0", $signed(psum_out), 2);
        smp(-1, 5, 0, 0, 0);
        chk("t3_o1", $signed(psum_out), 4);
        smp(1, 0, 0, 0, 0);
        chk("t3_o2", $signed(psum_out), 7);
        idle();
        chk("t3_o3", $signed(psum_out), 3);
        smp(1, 0, 0, 0, 0);
        chk("t3_v4", out_valid, 1);
        idle();
        chk("t3_gap", out_valid, 0);
        idle();
        chk("t3_v6", out_valid, 1);
        idle();

        smp(1, 99, 0, 1, 0);
        smp(2, 99, 0, 1, 0);
        smp(3, 99, 0, 1, 1);
        chk("t4_nov", out_valid, 0);
        idle(); idle();
        chk("t4_acc", $signed(psum_out), 12);
        chk("t4_vld", out_valid, 1);
        smp(4, 99, 0, 1, 1);
        idle(); idle();
        chk("t4_clr", $signed(psum_out), 8);

        load(0, 127);
        smp(127, 8388600, 0, 0, 0);
        idle(); idle();
        chk("t5_satp", $signed(psum_out), 8388607);
        chk("t5_wrap", $signed(psum_out_w), -8372487);
        load(1, 127);
        smp(-128, -8388600, 1, 0, 0);
        idle(); idle();
        chk("t5_satn", $signed(psum_out), -8388608);

        load(0, 3);
        step(0, 1, 0, 7, 1, 1, 0, 0, 0, 0);
        smp(1, 0, 0, 0, 0);
        idle();
        chk("t6_old", $signed(psum_out), 3);
        idle();
        chk("t6_new", $signed(psum_out), 7);

        smp(5, 5, 0, 0, 0);
        smp(6, 6, 0, 1, 0);
        smp(7, 7, 0, 0, 0);
        step(1, 1, 1, 50, 1, 8, 8, 0, 0, 0);
        chk("t7_rpsum", $signed(psum_out), 0);
        chk("t7_rovld", out_valid, 0);
        chk("t7_rif", $signed(ifmap_out), 0);
        idle(); idle(); idle();
        chk("t7_drop", out_valid, 0);
        load(0, 1);
        smp(3, 0, 0, 1, 1);
        idle(); idle();
        chk("t7_accdrop", $signed(psum_out), 3);

        for (int i = 0; i < 600; i++) begin
            x = int'($urandom_range(0, 255)) - 128;
            w = int'($urandom_range(0, 255)) - 128;
            p = int'($urandom_range(0, 16777215)) - 8388608;
            if ($urandom_range(0, 3) == 0)
                p = ($urandom_range(0, 1) == 1) ? 8388607 - int'($urandom_range(0, 20000))
                                                : -8388608 + int'($urandom_range(0, 20000));
            step($urandom_range(0, 79) == 0, $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 3)), w, $urandom_range(0, 3) != 0, x, p,
                 int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0);
        end
        idle(); idle(); idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
